// File: rtl/io_intr_pkg.sv
// rtl/io_intr_pkg.sv - shared encodings for the IO interrupt controller
package io_intr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACKD = 2'd2
   } state_e;

   localparam logic [3:0] OFF_PEND  = 4'h0;
   localparam logic [3:0] OFF_MASK  = 4'h4;
   localparam logic [3:0] OFF_CAUSE = 4'h8;
   localparam logic [3:0] OFF_STAT  = 4'hC;

   localparam int CAUSE_VALID_BIT = 31;
   localparam int CAUSE_ID_LSB    = 0;
   localparam int CAUSE_ID_W      = 4;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer with rising-edge pulse for one source
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic irq_i,
   output logic rise_o
);

   logic s1_q, s2_q, hist_q;

   // History resets low so a source held high through reset yields one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         s1_q   <= irq_i;
         s2_q   <= s1_q;
         hist_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~hist_q;

endmodule

// File: rtl/io_intr_ctrl.sv
// rtl/io_intr_ctrl.sv - pending/mask interrupt controller with CPU handshake FSM
module io_intr_ctrl
   import io_intr_pkg::*;
#(
   parameter int          NSRC = 4,
   parameter logic [11:0] BASE = 12'h7F0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src_irq,
   input  logic            io_cs,
   input  logic            io_wr,
   input  logic            io_rd,
   input  logic [11:0]     Address,
   input  logic [31:0]     D_In,
   output logic [31:0]     D_Out,
   output logic            intr,
   input  logic            intr_ack
);

   logic [NSRC-1:0] rise;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      irq_sync_edge u_sync (
         .clk    (clk),
         .rst    (rst),
         .irq_i  (src_irq[g]),
         .rise_o (rise[g])
      );
   end

   state_e          state_q, state_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic            cause_valid_q, cause_valid_d;
   logic [3:0]      cause_id_q, cause_id_d;
   logic            intr_q;

   logic            sel;
   logic [3:0]      off;
   logic            wr_pend, wr_mask, rd_cause;
   logic            unused_d_in;

   assign sel      = io_cs && (Address[11:4] == BASE[11:4]);
   assign off      = Address[3:0];
   assign wr_pend  = sel && io_wr && (off == OFF_PEND);
   assign wr_mask  = sel && io_wr && (off == OFF_MASK);
   assign rd_cause = sel && io_rd && (off == OFF_CAUSE);
   assign unused_d_in = ^D_In[31:NSRC];

   logic [NSRC-1:0] active;
   logic [NSRC-1:0] ack_onehot;
   logic [3:0]      ack_id;
   logic            found;
   logic            ack_fire;

   assign active = pend_q & mask_q;

   // Lowest index wins.
   always_comb begin
      ack_onehot = '0;
      ack_id     = 4'd0;
      found      = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (active[i] && !found) begin
            found         = 1'b1;
            ack_id        = 4'(i);
            ack_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ack_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|active) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (!(|active)) begin
               state_d = ST_IDLE;
            end else if (intr_ack) begin
               state_d  = ST_ACKD;
               ack_fire = 1'b1;
            end
         end
         ST_ACKD: begin
            if (!intr_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // New edges are OR-ed in last so a set always beats a same-cycle clear.
   always_comb begin
      pend_d = pend_q;
      if (wr_pend)  pend_d = pend_d & ~D_In[NSRC-1:0];
      if (ack_fire) pend_d = pend_d & ~ack_onehot;
      pend_d = pend_d | rise;

      mask_d = wr_mask ? D_In[NSRC-1:0] : mask_q;

      cause_valid_d = cause_valid_q;
      cause_id_d    = cause_id_q;
      if (rd_cause) cause_valid_d = 1'b0;
      if (ack_fire) begin
         cause_valid_d = 1'b1;
         cause_id_d    = ack_id;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         pend_q        <= '0;
         mask_q        <= '0;
         cause_valid_q <= 1'b0;
         cause_id_q    <= 4'd0;
         intr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         mask_q        <= mask_d;
         cause_valid_q <= cause_valid_d;
         cause_id_q    <= cause_id_d;
         intr_q        <= (state_d == ST_REQ);
      end
   end

   assign intr = intr_q;

   logic [31:0] cause_word;

   always_comb begin
      cause_word = '0;
      cause_word[CAUSE_VALID_BIT] = cause_valid_q;
      cause_word[CAUSE_ID_LSB +: CAUSE_ID_W] = cause_id_q;
   end

   always_comb begin
      D_Out = 32'h0;
      if (sel && io_rd) begin
         case (off)
            OFF_PEND:  D_Out = {{(32-NSRC){1'b0}}, pend_q};
            OFF_MASK:  D_Out = {{(32-NSRC){1'b0}}, mask_q};
            OFF_CAUSE: D_Out = cause_word;
            OFF_STAT:  D_Out = {30'b0, state_q};
            default:   D_Out = 32'h0;
         endcase
      end
   end

endmodule
